// File: rtl/crypt_pkg.sv
// Shared types and default frame geometry for the pixel encryption datapath.
package crypt_pkg;

  // Frame geometry shared with image_read / image_write.
  localparam int DEF_HSIZE = 768;  // pixel bytes per row, RGB interleaved
  localparam int DEF_VSIZE = 512;  // rows per frame

  // Key-refresh policy for one frame.
  typedef enum logic [1:0] {
    BYPASS    = 2'd0,
    FRAME_KEY = 2'd1,
    ROW_KEY   = 2'd2,
    BEAT_KEY  = 2'd3
  } crypt_mode_t;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_KEYLOAD = 2'd1,
    S_RUN     = 2'd2,
    S_DONE    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/frame_counter.sv
// Column/row beat position counter for one frame.
module frame_counter #(
  parameter int BEATS = 128,
  parameter int VSIZE = 512,
  parameter int CW    = $clog2(BEATS),
  parameter int RW    = $clog2(VSIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last_col,
  output logic          last_beat
);

  assign last_col  = (col == CW'(BEATS - 1));
  assign last_beat = last_col && (row == RW'(VSIZE - 1));

  // Advance column per beat, wrapping into the next row; clear wins.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      if (last_col) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/crypt_sequencer.sv
// Frame-level controller: arms a frame, steps the key generator per key mode,
// gates ECB enable, tracks beat position and flags dropped beats.
module crypt_sequencer
  import crypt_pkg::*;
#(
  parameter int HSIZE = DEF_HSIZE,
  parameter int VSIZE = DEF_VSIZE,
  parameter int CW    = $clog2(HSIZE / 6),
  parameter int RW    = $clog2(VSIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          hsync,
  output logic          key_step,
  output logic          enc_en,
  output logic [CW-1:0] col_cnt,
  output logic [RW-1:0] row_cnt,
  output logic          busy,
  output logic          frame_done,
  output logic          drop_err
);

  localparam int BEATS = HSIZE / 6;

  seq_state_t  state_q, state_d;
  crypt_mode_t mode_q, mode_d;
  logic        drop_d;
  logic        cnt_inc, cnt_clr;
  logic        last_col, last_beat;

  frame_counter #(
    .BEATS (BEATS),
    .VSIZE (VSIZE),
    .CW    (CW),
    .RW    (RW)
  ) u_frame_counter (
    .clk       (clk),
    .rst       (rst),
    .inc       (cnt_inc),
    .clr       (cnt_clr),
    .col       (col_cnt),
    .row       (row_cnt),
    .last_col  (last_col),
    .last_beat (last_beat)
  );

  // Next-state, counter control, Mealy key-step decode and drop detection.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    drop_d   = drop_err;
    key_step = 1'b0;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = crypt_mode_t'(mode);
          drop_d  = 1'b0;
          state_d = (crypt_mode_t'(mode) != BYPASS) ? S_KEYLOAD : S_RUN;
        end
      end
      S_KEYLOAD: begin
        // Fresh key at the top of every encrypted frame.
        key_step = 1'b1;
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (hsync) begin
          cnt_inc = 1'b1;
          // The current beat uses the pre-step key; the step takes effect next beat.
          case (mode_q)
            ROW_KEY:  key_step = last_col && !last_beat;
            BEAT_KEY: key_step = !last_beat;
            default:  key_step = 1'b0;
          endcase
          if (last_beat) begin
            cnt_clr = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A beat outside RUN is lost; this takes priority over the clear on start.
    if (hsync && state_q != S_RUN) drop_d = 1'b1;
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= BYPASS;
      enc_en     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      enc_en     <= (state_d == S_RUN) && (mode_d != BYPASS);
      busy       <= (state_d != S_IDLE);
      frame_done <= (state_d == S_DONE);
      drop_err   <= drop_d;
    end
  end

endmodule

// File: tb/tb_crypt_sequencer.sv
// Randomized self-checking bench for crypt_sequencer on a 4x3-beat frame.
module tb_crypt_sequencer;

  localparam int HSIZE = 24;
  localparam int VSIZE = 3;
  localparam int BEATS = HSIZE / 6;
  localparam int NB    = BEATS * VSIZE;
  localparam int CW    = $clog2(BEATS);
  localparam int RW    = $clog2(VSIZE);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic          hsync;
  logic          key_step;
  logic          enc_en;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          busy;
  logic          frame_done;
  logic          drop_err;

  int total = 0;
  int bad   = 0;
  logic exp_drop = 1'b0;

  crypt_sequencer #(.HSIZE(HSIZE), .VSIZE(VSIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .hsync      (hsync),
    .key_step   (key_step),
    .enc_en     (enc_en),
    .col_cnt    (col_cnt),
    .row_cnt    (row_cnt),
    .busy       (busy),
    .frame_done (frame_done),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled 1 unit later.
  task automatic drive(input logic s, input logic [1:0] m, input logic h);
    start = s;
    mode  = m;
    hsync = h;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Key step expected on beat k (0-based) of a frame in mode m.
  function automatic logic exp_step(input logic [1:0] m, input int k);
    case (m)
      2'd2:    return (k % BEATS == BEATS - 1) && (k != NB - 1);
      2'd3:    return (k != NB - 1);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int exp_pulses(input logic [1:0] m);
    case (m)
      2'd1:    return 1;
      2'd2:    return 1 + (VSIZE - 1);
      2'd3:    return 1 + (NB - 1);
      default: return 0;
    endcase
  endfunction

  task automatic idle_cycles(input int n);
    logic h;
    for (int i = 0; i < n; i++) begin
      h = 1'($urandom_range(0, 1));
      drive(1'b0, 2'($urandom), h);
      check("idle_busy", busy, 0);
      check("idle_key", key_step, 0);
      check("idle_enc", enc_en, 0);
      check("idle_pos", {col_cnt, row_cnt}, 0);
      check("idle_done", frame_done, 0);
      check("idle_drop", drop_err, exp_drop);
      tick();
      if (h) exp_drop = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [1:0] m, input int gap_pct, input int abort_at);
    int   k, cyc, pulses;
    logic h, s;
    // Start accepted this cycle.
    drive(1'b1, m, 1'b0);
    check("pre_busy", busy, 0);
    check("pre_drop", drop_err, exp_drop);
    tick();
    exp_drop = 1'b0;
    pulses = 0;
    if (m != 2'd0) begin
      // Key-load cycle: beats here are lost.
      h = ($urandom_range(0, 3) == 0);
      drive(1'b0, 2'($urandom), h);
      check("kl_key", key_step, 1);
      check("kl_enc", enc_en, 0);
      check("kl_busy", busy, 1);
      check("kl_drop", drop_err, exp_drop);
      if (key_step) pulses++;
      tick();
      if (h) exp_drop = 1'b1;
    end
    k = 0;
    cyc = 0;
    while (k < NB && cyc < 400) begin
      h = ($urandom_range(0, 99) >= gap_pct);
      s = ($urandom_range(0, 7) == 0);
      drive(s, 2'($urandom), h);
      check("run_busy", busy, 1);
      check("run_enc", enc_en, (m != 2'd0));
      check("run_col", col_cnt, k % BEATS);
      check("run_row", row_cnt, k / BEATS);
      check("run_done", frame_done, 0);
      check("run_drop", drop_err, exp_drop);
      check("run_key", key_step, h ? exp_step(m, k) : 1'b0);
      if (key_step) pulses++;
      tick();
      if (h) k++;
      cyc++;
      if (abort_at != 0 && k == abort_at) begin
        drive(1'b0, 2'd0, 1'b0);
        rst = 1'b1;
        #1;
        exp_drop = 1'b0;
        check("rst_key", key_step, 0);
        check("rst_enc", enc_en, 0);
        check("rst_busy", busy, 0);
        check("rst_pos", {col_cnt, row_cnt}, 0);
        check("rst_done", frame_done, 0);
        check("rst_drop", drop_err, 0);
        tick();
        check("rst_hold_done", frame_done, 0);
        check("rst_hold_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("post_rst_done", frame_done, 0);
        return;
      end
    end
    if (k < NB) check("frame_timeout", k, NB);
    // Done cycle.
    h = ($urandom_range(0, 3) == 0);
    drive(1'b0, 2'd0, h);
    check("done_pulse", frame_done, 1);
    check("done_busy", busy, 1);
    check("done_key", key_step, 0);
    check("done_enc", enc_en, 0);
    check("done_pos", {col_cnt, row_cnt}, 0);
    tick();
    if (h) exp_drop = 1'b1;
    // Back in idle.
    drive(1'b0, 2'd0, 1'b0);
    check("end_done", frame_done, 0);
    check("end_busy", busy, 0);
    check("end_drop", drop_err, exp_drop);
    check("key_pulses", pulses, exp_pulses(m));
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 1'b0);
    tick();
    tick();
    check("reset_key", key_step, 0);
    check("reset_enc", enc_en, 0);
    check("reset_busy", busy, 0);
    check("reset_pos", {col_cnt, row_cnt}, 0);
    check("reset_done", frame_done, 0);
    check("reset_drop", drop_err, 0);
    rst = 1'b0;
    tick();
    // Beat before start sets drop_err; the next start clears it.
    drive(1'b0, 2'd0, 1'b1);
    tick();
    exp_drop = 1'b1;
    idle_cycles(2);
    run_frame(2'd1, 0, 0);
    run_frame(2'd2, 40, 0);
    run_frame(2'd3, 0, 0);
    run_frame(2'd0, 20, 0);
    idle_cycles(3);
    run_frame(2'($urandom), 10, 6);
    run_frame(2'd3, 0, 0);
    for (int f = 0; f < 8; f++) begin
      idle_cycles($urandom_range(0, 3));
      run_frame(2'($urandom), $urandom_range(0, 60), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crypt_sequencer.md
# crypt_sequencer

Frame-level controller for the pixel encryption datapath. It sits between the image reader's beat stream (`hsync` = one valid pixel-pair beat) and the key generator / ECB stage. It arms a frame, steps the LFSR key generator according to the selected key-refresh mode, and gates the ECB enable. It also tracks column/row position, flags the end of the frame, and reports beats that arrive while no frame is armed.

## Interface

Parameters:
- `HSIZE`, 768: pixel bytes per row (RGB interleaved); beats per row `BEATS = HSIZE/6`, two pixels per beat.
- `VSIZE`, 512: rows per frame.
- `CW`, `$clog2(BEATS)`: column counter width (derived).
- `RW`, `$clog2(VSIZE)`: row counter width (derived).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to arm a frame; ignored while `busy`.
- `mode`  in  2  key mode, sampled on accepted `start`: 0 bypass, 1 frame key, 2 row key, 3 beat key.
- `hsync`  in  1  pixel-pair beat valid.
- `key_step`  out  1  enable to `param_lfsr`; the LFSR advances on the edge where this is high.
- `enc_en`  out  1  enable to `ecb_mode`.
- `col_cnt`  out  CW  beat index within the row.
- `row_cnt`  out  RW  row index.
- `busy`  out  1  high from accepted `start` until the end of DONE.
- `frame_done`  out  1  one-cycle pulse after the last beat of a frame.
- `drop_err`  out  1  sticky flag: a beat arrived while not in RUN.

## Operation

- States: IDLE, KEYLOAD, RUN, DONE.
- IDLE:
  - `start` → latch `mode` into `mode_q` and clear `drop_err`.
  - Next state is KEYLOAD if `mode!=0`, else RUN.
- KEYLOAD: exactly one cycle. `key_step=1`, so each frame starts with a fresh key. Next state is RUN.
- RUN:
  - `enc_en = (mode_q!=0)`.
  - Each `hsync` beat increments `col_cnt`.
  - At `col_cnt==BEATS-1`, `col_cnt` wraps to 0 and `row_cnt` increments.
  - On the beat where `col_cnt==BEATS-1` and `row_cnt==VSIZE-1`, the next state is DONE and both counters clear to 0.
- DONE: one cycle. `frame_done=1`. Next state is IDLE.
- `key_step` in RUN is a Mealy output (combinational on `hsync`):
  - Mode 1: never.
  - Mode 2: on `hsync` with `col_cnt==BEATS-1` and `row_cnt!=VSIZE-1`.
  - Mode 3: on every `hsync` except the final beat of the frame.
- In every case the current beat is encrypted with the pre-step key.
- Mode 0: `key_step` and `enc_en` stay 0 for the whole frame; counting and `frame_done` behave the same as in the other modes.
- Beats outside RUN are not counted and set `drop_err`. The flag holds until the next accepted `start`.
- `start` while `busy` is ignored; it does not affect `drop_err`. `mode` changes after acceptance are ignored.

## Timing

- All state, counters, `enc_en`, `busy`, `frame_done` and `drop_err` are registered. `key_step` is registered in KEYLOAD and combinational in RUN.
- Reset value of every output is 0; the state resets to IDLE.
- Reset asserted mid-frame: immediate return to IDLE with counters 0. No `frame_done` is generated.
- Latencies:
  - `start` accepted at cycle N: `busy=1` from N+1.
  - Modes 1–3: KEYLOAD at N+1, RUN from N+2.
  - Mode 0: RUN from N+1.
- The first beat counted is the first `hsync` in RUN. A beat coinciding with KEYLOAD is dropped.
- Final beat at cycle M: DONE at M+1 (`frame_done=1`, `busy=1`); IDLE at M+2 (`busy=0`).
- Back-to-back frames: the earliest next `start` is accepted at M+2.
- No gap is required between rows; continuous `hsync` is supported.

## Structure

- Shared package `crypt_pkg`:
  - `crypt_mode_t` enum: BYPASS, FRAME_KEY, ROW_KEY, BEAT_KEY.
  - `seq_state_t` enum.
  - Default `HSIZE`/`VSIZE` constants, shared with `image_read`/`image_write`.
- One sub-module, `frame_counter`:
  - Parameterised column/row counter.
  - Inputs: `inc`, `clr`.
  - Outputs: `col`, `row`, `last_col`, `last_beat`.
- The FSM and key-step decode live in the top level.

## Test plan

All scenarios use HSIZE=24, VSIZE=3, so BEATS=4 and a frame is 12 beats.

- Mode 1, `start`, then 12 continuous beats:
  - `key_step` only in KEYLOAD (1 pulse total).
  - `enc_en=1` through RUN.
  - `frame_done` one cycle after beat 12; `busy` drops the cycle after that.
- Mode 2, 12 beats with gaps:
  - `key_step` on beats 4 and 8 only (3 pulses including KEYLOAD).
  - `row_cnt` sequence 0,1,2; `col_cnt` wraps 3→0.
- Mode 3, 12 continuous beats:
  - `key_step` on beats 1–11, not on beat 12; 12 pulses including KEYLOAD.
- Mode 0:
  - `enc_en`/`key_step` never high.
  - RUN entered one cycle after `start`.
  - `frame_done` after 12 beats.
- Beat before `start` → `drop_err=1`; `start` clears it. A second `start` during RUN → ignored, and `mode_q` is unchanged.
- `rst` asserted after beat 6:
  - All outputs 0 immediately and the state is IDLE.
  - No `frame_done`.
  - A new `start` runs a full 12-beat frame.
